// File: rtl/recog_pkg.sv
// Shared definitions for the two-source ASCII sequence recognizer.
package recog_pkg;

    localparam int unsigned DEFAULT_CW    = 7;
    localparam int unsigned DEFAULT_DEPTH = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2,
        FLUSH = 2'd3
    } state_t;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/recog_window.sv
// Sliding window of the last DEPTH accepted chars, fill tracking and pattern compare.
module recog_window
    import recog_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned CW    = DEFAULT_CW
) (
    input  logic                CLK,
    input  logic                RST_n,
    input  logic                shift_en,
    input  logic                clr,
    input  logic [CW-1:0]       char_in,
    input  logic [DEPTH*CW-1:0] pattern,
    output logic                full,
    output logic                hit
);

    localparam int unsigned FW = $clog2(DEPTH + 1);

    // Slot 0 (oldest) sits in the low bits, slot DEPTH-1 (newest) in the high bits.
    logic [DEPTH*CW-1:0] r_win;
    logic [FW-1:0]       r_fill;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_win  <= '0;
            r_fill <= '0;
        end else if (clr) begin
            r_fill <= '0;
        end else if (shift_en) begin
            r_win <= {char_in, r_win[DEPTH*CW-1:CW]};
            if (r_fill != FW'(DEPTH)) begin
                r_fill <= r_fill + FW'(1);
            end
        end
    end

    assign full = (r_fill == FW'(DEPTH));
    assign hit  = full & (r_win == pattern);

endmodule

// File: rtl/recog_stream_ctrl.sv
// Round-robin arbiter sharing one sequence recognizer between char sources A and B.
module recog_stream_ctrl
    import recog_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned CW    = DEFAULT_CW,
    parameter int unsigned CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             arm,
    input  logic             flush,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_idx,
    input  logic [CW-1:0]    cfg_char,
    input  logic             a_valid,
    input  logic [CW-1:0]    a_char,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [CW-1:0]    b_char,
    output logic             b_ready,
    output logic             match,
    output logic             match_src,
    output logic [CNT_W-1:0] hit_count,
    output logic             busy
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_rr;
    logic                w_rr_nxt;
    logic [DEPTH*CW-1:0] r_pat;
    logic                r_cmp_pend;
    logic                r_cmp_src;
    logic                r_match;
    logic                r_match_src;
    logic [CNT_W-1:0]    r_hit_cnt;

    logic                w_a_ready;
    logic                w_b_ready;
    logic                w_acc_a;
    logic                w_acc_b;
    logic                w_acc;
    logic [CW-1:0]       w_acc_char;
    logic                w_clr;
    logic                w_full;
    logic                w_hit;
    logic                w_fire;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state <= IDLE;
            r_rr    <= SRC_A;
        end else begin
            r_state <= w_state_nxt;
            r_rr    <= w_rr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr;
        case (r_state)
            IDLE: begin
                if (arm) begin
                    if (a_valid && (!b_valid || r_rr == SRC_A)) begin
                        w_state_nxt = GNT_A;
                    end else if (b_valid) begin
                        w_state_nxt = GNT_B;
                    end
                end
            end
            GNT_A: begin
                if (!(a_valid && arm)) begin
                    w_state_nxt = FLUSH;
                    w_rr_nxt    = SRC_B;
                end
            end
            GNT_B: begin
                if (!(b_valid && arm)) begin
                    w_state_nxt = FLUSH;
                    w_rr_nxt    = SRC_A;
                end
            end
            FLUSH:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_a_ready  = (r_state == GNT_A) & arm & ~flush;
    assign w_b_ready  = (r_state == GNT_B) & arm & ~flush;
    assign w_acc_a    = a_valid & w_a_ready;
    assign w_acc_b    = b_valid & w_b_ready;
    assign w_acc      = w_acc_a | w_acc_b;
    assign w_acc_char = w_acc_b ? b_char : a_char;
    // Leaving a grant always passes through FLUSH, so every burst starts empty.
    assign w_clr      = flush | (r_state == FLUSH);

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_pat <= '0;
        end else if (cfg_we && !arm) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (cfg_idx == 3'(i)) begin
                    r_pat[i*CW +: CW] <= cfg_char;
                end
            end
        end
    end

    recog_window #(
        .DEPTH(DEPTH),
        .CW   (CW)
    ) u_window (
        .CLK     (CLK),
        .RST_n   (RST_n),
        .shift_en(w_acc),
        .clr     (w_clr),
        .char_in (w_acc_char),
        .pattern (r_pat),
        .full    (w_full),
        .hit     (w_hit)
    );

    // The compare runs the cycle after an accept, against the updated window;
    // a flush in that cycle clears fill only at its closing edge, so it still fires.
    assign w_fire = r_cmp_pend & w_hit;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_cmp_pend  <= 1'b0;
            r_cmp_src   <= SRC_A;
            r_match     <= 1'b0;
            r_match_src <= SRC_A;
            r_hit_cnt   <= '0;
        end else begin
            r_cmp_pend  <= w_acc;
            r_cmp_src   <= w_acc_b;
            r_match     <= w_fire;
            r_match_src <= w_fire & r_cmp_src;
            if (w_fire && r_hit_cnt != '1) begin
                r_hit_cnt <= r_hit_cnt + CNT_W'(1);
            end
        end
    end

    assign a_ready   = w_a_ready;
    assign b_ready   = w_b_ready;
    assign match     = r_match;
    assign match_src = r_match_src;
    assign hit_count = r_hit_cnt;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_recog_stream_ctrl.sv
// Scoreboarded bench for recog_stream_ctrl: model window predicts match pulses.
module tb_recog_stream_ctrl;

    localparam int unsigned DEPTH = recog_pkg::DEFAULT_DEPTH;
    localparam int unsigned CW    = recog_pkg::DEFAULT_CW;
    localparam int unsigned CNT_W = 8;

    logic             CLK = 1'b0;
    logic             RST_n;
    logic             arm, flush, cfg_we;
    logic [2:0]       cfg_idx;
    logic [CW-1:0]    cfg_char, a_char, b_char;
    logic             a_valid, b_valid;
    logic             a_ready, b_ready, match, match_src, busy;
    logic [CNT_W-1:0] hit_count;
    logic             s_a_ready, s_b_ready, s_match, s_match_src, s_busy;
    logic [1:0]       s_hit_count;

    int n_cmp = 0;
    int n_err = 0;
    int ncyc  = 0;

    typedef struct {
        int   cyc;
        logic src;
    } exp_t;
    exp_t q[$];

    logic [CW-1:0] m_win[DEPTH];
    logic [CW-1:0] m_pat[DEPTH];
    int            m_fill = 0;
    int            m_hits = 0;

    always #5 CLK = ~CLK;

    recog_stream_ctrl #(.DEPTH(DEPTH), .CW(CW), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST_n(RST_n), .arm(arm), .flush(flush),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_char(cfg_char),
        .a_valid(a_valid), .a_char(a_char), .a_ready(a_ready),
        .b_valid(b_valid), .b_char(b_char), .b_ready(b_ready),
        .match(match), .match_src(match_src), .hit_count(hit_count), .busy(busy)
    );

    recog_stream_ctrl #(.DEPTH(DEPTH), .CW(CW), .CNT_W(2)) dut_sat (
        .CLK(CLK), .RST_n(RST_n), .arm(arm), .flush(flush),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_char(cfg_char),
        .a_valid(a_valid), .a_char(a_char), .a_ready(s_a_ready),
        .b_valid(b_valid), .b_char(b_char), .b_ready(s_b_ready),
        .match(s_match), .match_src(s_match_src), .hit_count(s_hit_count), .busy(s_busy)
    );

    // Scoreboard: accepts observed here predict a pulse two negedges later.
    always @(negedge CLK) begin
        ncyc++;
        if (!RST_n) begin
            q.delete();
            m_fill = 0;
            m_hits = 0;
            for (int j = 0; j < DEPTH; j++) m_win[j] = '0;
        end else begin
            if (q.size() > 0 && q[0].cyc == ncyc) begin
                if (m_hits < (1 << CNT_W) - 1) m_hits++;
                n_cmp++;
                if (match !== 1'b1 || match_src !== q[0].src) begin
                    n_err++;
                    $display("FAIL sb_match cyc=%0d got match=%b src=%b, expected match=1 src=%b",
                             ncyc, match, match_src, q[0].src);
                end
                n_cmp++;
                if (hit_count !== CNT_W'(m_hits)) begin
                    n_err++;
                    $display("FAIL sb_hit_count cyc=%0d got %0d, expected %0d", ncyc, hit_count, m_hits);
                end
                void'(q.pop_front());
            end else begin
                n_cmp++;
                if (match !== 1'b0) begin
                    n_err++;
                    $display("FAIL sb_spurious_match cyc=%0d got match=%b, expected 0", ncyc, match);
                end
            end
            if (a_ready === 1'b0 && b_ready === 1'b0) begin
                m_fill = 0;
            end else if ((a_valid && a_ready) || (b_valid && b_ready)) begin
                logic src;
                bit   eq;
                src = b_valid && b_ready;
                for (int j = 0; j < DEPTH - 1; j++) m_win[j] = m_win[j+1];
                m_win[DEPTH-1] = src ? b_char : a_char;
                if (m_fill < DEPTH) m_fill++;
                eq = 1'b1;
                for (int j = 0; j < DEPTH; j++) if (m_win[j] !== m_pat[j]) eq = 1'b0;
                if (m_fill == DEPTH && eq) q.push_back('{ncyc + 2, src});
            end
        end
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset;
        RST_n = 1'b0; arm = 1'b0; flush = 1'b0; cfg_we = 1'b0;
        cfg_idx = '0; cfg_char = '0;
        a_valid = 1'b0; b_valid = 1'b0; a_char = '0; b_char = '0;
        for (int j = 0; j < DEPTH; j++) m_pat[j] = '0;
        repeat (2) tick;
        RST_n = 1'b1;
        tick;
    endtask

    task automatic prog_pattern(input string s);
        arm = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            cfg_we   = 1'b1;
            cfg_idx  = 3'(i);
            cfg_char = CW'(s[i]);
            m_pat[i] = CW'(s[i]);
            tick;
        end
        cfg_we = 1'b0;
    endtask

    task automatic send(input logic src, input string s, input bit keep, output int stalls);
        stalls = 0;
        for (int i = 0; i < s.len(); i++) begin
            bit done;
            int t;
            done = 1'b0;
            t    = 0;
            if (src) begin b_valid = 1'b1; b_char = CW'(s[i]); end
            else     begin a_valid = 1'b1; a_char = CW'(s[i]); end
            while (!done && t < 20) begin
                @(negedge CLK);
                done = src ? (b_ready === 1'b1) : (a_ready === 1'b1);
                if (!done) stalls++;
                t++;
                @(posedge CLK);
                #1;
            end
            n_cmp++;
            if (!done) begin
                n_err++;
                $display("FAIL send_timeout src=%0d char %0d got no ready in %0d cycles, expected accept", src, i, t);
            end
        end
        if (!keep) begin
            a_valid = 1'b0;
            b_valid = 1'b0;
        end
    endtask

    task automatic test_reset;
        RST_n = 1'b0; arm = 1'b1; flush = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_char = '0;
        a_valid = 1'b1; b_valid = 1'b1; a_char = 7'h41; b_char = 7'h42;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        n_cmp++;
        if ({a_ready, b_ready, match, match_src, busy} !== 5'b0 || hit_count !== '0 || s_hit_count !== 2'd0) begin
            n_err++;
            $display("FAIL reset_outputs got rdy=%b%b match=%b src=%b busy=%b hits=%0d, expected all 0",
                     a_ready, b_ready, match, match_src, busy, hit_count);
        end
        do_reset;
    endtask

    task automatic test_james;
        int st;
        do_reset;
        prog_pattern("JAMES");
        arm = 1'b1;
        send(1'b0, "JAMES", 1'b0, st);
        n_cmp++;
        if (st != 1) begin
            n_err++;
            $display("FAIL james_ready_held got %0d stall cycles, expected 1", st);
        end
        @(negedge CLK);
        n_cmp++;
        if (match !== 1'b0) begin
            n_err++;
            $display("FAIL james_match_early got match=%b, expected 0", match);
        end
        @(negedge CLK);
        n_cmp++;
        if (match !== 1'b1 || match_src !== 1'b0 || hit_count !== 8'd1) begin
            n_err++;
            $display("FAIL james_match got match=%b src=%b hits=%0d, expected 1 0 1", match, match_src, hit_count);
        end
        repeat (3) tick;
    endtask

    task automatic test_arbitration;
        do_reset;
        arm = 1'b1; a_valid = 1'b1; b_valid = 1'b1; a_char = 7'h78; b_char = 7'h79;
        @(negedge CLK);
        n_cmp++;
        if ({a_ready, b_ready, busy} !== 3'b000) begin
            n_err++;
            $display("FAIL arb_idle got rdy=%b%b busy=%b, expected 000", a_ready, b_ready, busy);
        end
        tick;
        @(negedge CLK);
        n_cmp++;
        if ({a_ready, b_ready, busy} !== 3'b101) begin
            n_err++;
            $display("FAIL arb_first_a got rdy=%b%b busy=%b, expected 101", a_ready, b_ready, busy);
        end
        tick;
        a_valid = 1'b0;
        tick;
        a_valid = 1'b1;
        @(negedge CLK);
        n_cmp++;
        if ({a_ready, b_ready, busy} !== 3'b001) begin
            n_err++;
            $display("FAIL arb_flush got rdy=%b%b busy=%b, expected 001", a_ready, b_ready, busy);
        end
        tick;
        @(negedge CLK);
        n_cmp++;
        if ({a_ready, b_ready, busy} !== 3'b000) begin
            n_err++;
            $display("FAIL arb_back_idle got rdy=%b%b busy=%b, expected 000", a_ready, b_ready, busy);
        end
        tick;
        @(negedge CLK);
        n_cmp++;
        if ({a_ready, b_ready, busy} !== 3'b011) begin
            n_err++;
            $display("FAIL arb_rr_b got rdy=%b%b busy=%b, expected 011", a_ready, b_ready, busy);
        end
        tick;
        b_valid = 1'b0;
        repeat (3) tick;
        @(negedge CLK);
        n_cmp++;
        if ({a_ready, b_ready, busy} !== 3'b101) begin
            n_err++;
            $display("FAIL arb_rr_back_a got rdy=%b%b busy=%b, expected 101", a_ready, b_ready, busy);
        end
        a_valid = 1'b0;
        repeat (3) tick;
    endtask

    task automatic test_no_span;
        int st;
        do_reset;
        prog_pattern("JAMES");
        arm = 1'b1;
        send(1'b0, "JAM", 1'b0, st);
        send(1'b1, "ES", 1'b0, st);
        repeat (4) tick;
        n_cmp++;
        if (hit_count !== 8'd0) begin
            n_err++;
            $display("FAIL no_span_hits got %0d, expected 0", hit_count);
        end
    endtask

    task automatic test_back_to_back;
        int st;
        do_reset;
        prog_pattern("AAAAA");
        arm = 1'b1;
        send(1'b0, "AAAAAAA", 1'b0, st);
        repeat (4) tick;
        n_cmp++;
        if (hit_count !== 8'd3) begin
            n_err++;
            $display("FAIL b2b_hits got %0d, expected 3", hit_count);
        end
    endtask

    task automatic test_flush;
        int st;
        do_reset;
        prog_pattern("JAMES");
        arm = 1'b1;
        send(1'b0, "JA", 1'b1, st);
        a_char = 7'h4D;
        flush  = 1'b1;
        @(negedge CLK);
        n_cmp++;
        if (a_ready !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL flush_ready got a_ready=%b busy=%b, expected 0 1", a_ready, busy);
        end
        tick;
        flush = 1'b0;
        send(1'b0, "MESJAMES", 1'b0, st);
        repeat (4) tick;
        n_cmp++;
        if (hit_count !== 8'd1) begin
            n_err++;
            $display("FAIL flush_hits got %0d, expected 1", hit_count);
        end
    endtask

    task automatic test_cfg_locked;
        int st;
        do_reset;
        prog_pattern("JAMES");
        cfg_we = 1'b1; cfg_idx = 3'd6; cfg_char = 7'h5A;
        tick;
        arm = 1'b1; cfg_idx = 3'd0; cfg_char = 7'h58;
        tick;
        cfg_idx = 3'd4;
        tick;
        cfg_we = 1'b0;
        send(1'b0, "JAMES", 1'b0, st);
        repeat (4) tick;
        n_cmp++;
        if (hit_count !== 8'd1) begin
            n_err++;
            $display("FAIL cfg_locked_hits got %0d, expected 1", hit_count);
        end
    endtask

    task automatic test_saturation;
        int st;
        do_reset;
        prog_pattern("AAAAA");
        arm = 1'b1;
        send(1'b0, "AAAAAAAAA", 1'b0, st);
        repeat (4) tick;
        n_cmp++;
        if (hit_count !== 8'd5 || s_hit_count !== 2'd3) begin
            n_err++;
            $display("FAIL saturation got hits=%0d sat_hits=%0d, expected 5 3", hit_count, s_hit_count);
        end
    endtask

    task automatic test_async_reset;
        int st;
        do_reset;
        prog_pattern("JAMES");
        arm = 1'b1;
        send(1'b0, "JAMES", 1'b1, st);
        send(1'b0, "JAMES", 1'b1, st);
        n_cmp++;
        if (hit_count !== 8'd1 || a_ready !== 1'b1) begin
            n_err++;
            $display("FAIL areset_pre got hits=%0d a_ready=%b, expected 1 1", hit_count, a_ready);
        end
        #1;
        RST_n = 1'b0;
        for (int j = 0; j < DEPTH; j++) m_pat[j] = '0;
        #1;
        n_cmp++;
        if ({a_ready, b_ready, match, match_src, busy} !== 5'b0 || hit_count !== '0) begin
            n_err++;
            $display("FAIL areset_immediate got rdy=%b%b match=%b busy=%b hits=%0d, expected all 0",
                     a_ready, b_ready, match, busy, hit_count);
        end
        repeat (2) tick;
        n_cmp++;
        if (match !== 1'b0 || hit_count !== '0) begin
            n_err++;
            $display("FAIL areset_pending_lost got match=%b hits=%0d, expected 0 0", match, hit_count);
        end
        RST_n = 1'b1;
        send(1'b0, "JAMES", 1'b0, st);
        repeat (4) tick;
        n_cmp++;
        if (hit_count !== 8'd0) begin
            n_err++;
            $display("FAIL areset_pattern_cleared got hits=%0d, expected 0", hit_count);
        end
    endtask

    initial begin
        test_reset;
        test_james;
        test_arbitration;
        test_no_span;
        test_back_to_back;
        test_flush;
        test_cfg_locked;
        test_saturation;
        test_async_reset;
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL sb_leftover got %0d pending matches, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got no finish by t=500000, expected completion");
        $fatal(1, "bench timeout");
    end

endmodule
